// File: rtl/pca_pkg.sv
// Shared types and constants for the PCA accelerator's Jacobi eigen-solver blocks.
package pca_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WAIT_COV,
    ST_ISSUE,
    ST_WAIT_CS,
    ST_ROTATE,
    ST_WAIT_ROT,
    ST_ADVANCE,
    ST_DONE,
    ST_ERR
  } sched_state_t;

  // Index fields are sized for the largest supported matrix; users slice to their IDX_W.
  localparam int PAIR_IDX_MAX_W = 8;

  typedef struct packed {
    logic [PAIR_IDX_MAX_W-1:0] p;
    logic [PAIR_IDX_MAX_W-1:0] q;
  } pair_t;

  localparam int DEFAULT_MATRIX_SIZE = 4;
  localparam int PAIRS_PER_SWEEP     = DEFAULT_MATRIX_SIZE * (DEFAULT_MATRIX_SIZE - 1) / 2;

  function automatic int pairs_per_sweep(input int n);
    return n * (n - 1) / 2;
  endfunction

endpackage

// File: rtl/jacobi_pair_gen.sv
// Combinational cyclic-by-row successor of an off-diagonal pair (p,q), q > p.
// wrap flags the end of a sweep, where the successor restarts at (0,1).
module jacobi_pair_gen #(
  parameter int MATRIX_SIZE = 4,
  parameter int IDX_W       = $clog2(MATRIX_SIZE)
) (
  input  logic [IDX_W-1:0] p,
  input  logic [IDX_W-1:0] q,
  output logic [IDX_W-1:0] next_p,
  output logic [IDX_W-1:0] next_q,
  output logic             wrap
);

  localparam logic [IDX_W-1:0] LAST_Q = IDX_W'(MATRIX_SIZE - 1);
  localparam logic [IDX_W-1:0] LAST_P = IDX_W'(MATRIX_SIZE - 2);

  always_comb begin
    next_p = '0;
    next_q = IDX_W'(1);
    wrap   = 1'b0;
    if (q < LAST_Q) begin
      next_p = p;
      next_q = q + IDX_W'(1);
    end else if (p < LAST_P) begin
      next_p = p + IDX_W'(1);
      next_q = p + IDX_W'(2);
    end else begin
      wrap = 1'b1;
    end
  end

endmodule

// File: rtl/jacobi_sweep_scheduler.sv
// Walks (p,q) pairs for NUM_SWEEPS Jacobi sweeps, handshaking with the CORDIC
// and Givens units; each handshake is guarded by a TIMEOUT-cycle watchdog.
module jacobi_sweep_scheduler
  import pca_pkg::*;
#(
  parameter int MATRIX_SIZE = 4,
  parameter int NUM_SWEEPS  = 4,
  parameter int TIMEOUT     = 64,
  parameter int IDX_W       = $clog2(MATRIX_SIZE),
  parameter int SC_W        = $clog2(NUM_SWEEPS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cov_ready,
  output logic [IDX_W-1:0] p,
  output logic [IDX_W-1:0] q,
  output logic             arctan_valid,
  input  logic             sincos_valid,
  output logic             rot_start,
  input  logic             rot_done,
  output logic [SC_W-1:0]  sweep_count,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  sched_state_t     state_reg;
  logic [IDX_W-1:0] p_reg, q_reg;
  logic [IDX_W-1:0] p_next, q_next;
  logic             pair_wrap;
  logic [SC_W-1:0]  sweep_reg;
  logic [SC_W-1:0]  sweep_next;
  logic [WD_W-1:0]  wd_reg;
  logic             wd_expired;
  logic             arctan_valid_reg, rot_start_reg;
  logic             busy_reg, done_reg, err_reg;

  jacobi_pair_gen #(
    .MATRIX_SIZE (MATRIX_SIZE),
    .IDX_W       (IDX_W)
  ) u_pair_gen (
    .p      (p_reg),
    .q      (q_reg),
    .next_p (p_next),
    .next_q (q_next),
    .wrap   (pair_wrap)
  );

  assign sweep_next = sweep_reg + SC_W'(1);
  // wd_reg holds the current wait-cycle number (1-based), so expiry is on cycle TIMEOUT.
  assign wd_expired = (wd_reg == WD_W'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= ST_IDLE;
      p_reg            <= '0;
      q_reg            <= IDX_W'(1);
      sweep_reg        <= '0;
      wd_reg           <= '0;
      arctan_valid_reg <= 1'b0;
      rot_start_reg    <= 1'b0;
      busy_reg         <= 1'b0;
      done_reg         <= 1'b0;
      err_reg          <= 1'b0;
    end else begin
      arctan_valid_reg <= 1'b0;
      rot_start_reg    <= 1'b0;
      case (state_reg)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state_reg <= ST_WAIT_COV;
            p_reg     <= '0;
            q_reg     <= IDX_W'(1);
            sweep_reg <= '0;
            busy_reg  <= 1'b1;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
          end
        end
        ST_WAIT_COV: begin
          if (cov_ready) begin
            state_reg        <= ST_ISSUE;
            arctan_valid_reg <= 1'b1;
          end
        end
        ST_ISSUE: begin
          state_reg <= ST_WAIT_CS;
          wd_reg    <= WD_W'(1);
        end
        ST_WAIT_CS: begin
          if (sincos_valid) begin
            state_reg     <= ST_ROTATE;
            rot_start_reg <= 1'b1;
          end else if (wd_expired) begin
            state_reg <= ST_ERR;
            busy_reg  <= 1'b0;
            err_reg   <= 1'b1;
          end else begin
            wd_reg <= wd_reg + WD_W'(1);
          end
        end
        ST_ROTATE: begin
          state_reg <= ST_WAIT_ROT;
          wd_reg    <= WD_W'(1);
        end
        ST_WAIT_ROT: begin
          if (rot_done) begin
            state_reg <= ST_ADVANCE;
          end else if (wd_expired) begin
            state_reg <= ST_ERR;
            busy_reg  <= 1'b0;
            err_reg   <= 1'b1;
          end else begin
            wd_reg <= wd_reg + WD_W'(1);
          end
        end
        ST_ADVANCE: begin
          p_reg <= p_next;
          q_reg <= q_next;
          if (pair_wrap && (sweep_next == SC_W'(NUM_SWEEPS))) begin
            sweep_reg <= sweep_next;
            state_reg <= ST_DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end else begin
            if (pair_wrap) begin
              sweep_reg <= sweep_next;
            end
            state_reg        <= ST_ISSUE;
            arctan_valid_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign p            = p_reg;
  assign q            = q_reg;
  assign sweep_count  = sweep_reg;
  assign arctan_valid = arctan_valid_reg;
  assign rot_start    = rot_start_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;
  assign err          = err_reg;

endmodule

// File: tb/tb_jacobi_sweep_scheduler.sv
// Self-checking bench: expected pair order comes from nested loops over the
// upper triangle; handshake delays are randomized.
module tb_jacobi_sweep_scheduler;

  localparam int N   = 4;
  localparam int SW  = 2;
  localparam int TO  = 64;
  localparam int PPS = N * (N - 1) / 2;

  logic       clk = 1'b0;
  logic       rst, start, cov_ready, sincos_valid, rot_done;
  logic [1:0] p, q;
  logic       arctan_valid, rot_start, busy, done, err;
  logic [1:0] sweep_count;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  jacobi_sweep_scheduler #(
    .MATRIX_SIZE (N),
    .NUM_SWEEPS  (SW),
    .TIMEOUT     (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .cov_ready    (cov_ready),
    .p            (p),
    .q            (q),
    .arctan_valid (arctan_valid),
    .sincos_valid (sincos_valid),
    .rot_start    (rot_start),
    .rot_done     (rot_done),
    .sweep_count  (sweep_count),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_idle_flags(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_arctan"}, arctan_valid, 0);
    check({tag, "_rot_start"}, rot_start, 0);
    check({tag, "_p"}, p, 0);
    check({tag, "_q"}, q, 1);
    check({tag, "_sweep"}, sweep_count, 0);
  endtask

  // Start is sampled on the next edge; afterwards the block sits in WAIT_COV.
  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_done", done, 0);
    check("start_err", err, 0);
    check("start_p", p, 0);
    check("start_q", q, 1);
    check("start_sweep", sweep_count, 0);
    check("start_arctan", arctan_valid, 0);
  endtask

  // Entered during the ISSUE cycle; returns during the ADVANCE cycle.
  task automatic do_pair(input int ds, input int dr, input int ep, input int eq, input bit spur);
    check("issue_arctan", arctan_valid, 1);
    check("issue_p", p, ep);
    check("issue_q", q, eq);
    tick();
    check("arctan_one_cycle", arctan_valid, 0);
    for (int w = 1; w < ds; w++) begin
      if (spur && w == 1) begin
        rot_done = 1'b1;
        start    = 1'b1;
      end
      tick();
      rot_done = 1'b0;
      start    = 1'b0;
      check("cs_no_rot_start", rot_start, 0);
      check("cs_busy", busy, 1);
      check("cs_p_stable", p, ep);
      check("cs_q_stable", q, eq);
    end
    sincos_valid = 1'b1;
    tick();
    sincos_valid = 1'b0;
    check("rot_start", rot_start, 1);
    tick();
    check("rot_start_one_cycle", rot_start, 0);
    for (int w = 1; w < dr; w++) begin
      tick();
      check("rot_p_stable", p, ep);
      check("rot_q_stable", q, eq);
      check("rot_no_arctan", arctan_valid, 0);
    end
    rot_done = 1'b1;
    tick();
    rot_done = 1'b0;
    check("adv_busy", busy, 1);
    check("adv_p_stable", p, ep);
    check("adv_q_stable", q, eq);
  endtask

  task automatic run_all(input bit rnd);
    int exp_p[$];
    int exp_q[$];
    int last_issue;
    int ds, dr;
    bit spur;
    for (int s = 0; s < SW; s++)
      for (int a = 0; a < N; a++)
        for (int b = a + 1; b < N; b++) begin
          exp_p.push_back(a);
          exp_q.push_back(b);
        end
    start_pulse();
    tick();
    check("first_arctan_latency", arctan_valid, 1);
    last_issue = cyc;
    for (int i = 0; i < exp_p.size(); i++) begin
      if (i > 0) begin
        check("next_issue_arctan", arctan_valid, 1);
        if (!rnd) check("issue_spacing", cyc - last_issue, 5);
      end
      last_issue = cyc;
      check("issue_sweep_count", sweep_count, i / PPS);
      ds   = rnd ? int'($urandom_range(1, 40)) : 1;
      dr   = rnd ? int'($urandom_range(1, 40)) : 1;
      spur = rnd && ds >= 2 && ($urandom_range(0, 3) == 0);
      $display("pair %0d p=%0d q=%0d ds=%0d dr=%0d spur=%0d", i, exp_p[i], exp_q[i], ds, dr, spur);
      do_pair(ds, dr, exp_p[i], exp_q[i], spur);
      tick();
    end
    check("run_done", done, 1);
    check("run_busy", busy, 0);
    check("run_sweep_count", sweep_count, SW);
    check("run_p_wrapped", p, 0);
    check("run_q_wrapped", q, 1);
    check("run_no_arctan", arctan_valid, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cov_ready = 1'b1; sincos_valid = 1'b0; rot_done = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_idle_flags("reset");

    // Minimum-latency run, then a restart from DONE with random back-pressure.
    run_all(1'b0);
    run_all(1'b1);

    // Cov gating from DONE, then watchdog boundaries.
    cov_ready = 1'b0;
    start_pulse();
    for (int i = 0; i < 10; i++) begin
      tick();
      check("covgate_no_arctan", arctan_valid, 0);
      check("covgate_busy", busy, 1);
    end
    cov_ready = 1'b1;
    tick();
    check("covgate_arctan", arctan_valid, 1);
    $display("watchdog boundary pair p=0 q=1 ds=%0d dr=%0d", TO, TO);
    do_pair(TO, TO, 0, 1, 1'b0);
    tick();
    check("wd_ok_err", err, 0);
    check("wd_next_p", p, 0);
    check("wd_next_q", q, 2);
    check("wd_next_arctan", arctan_valid, 1);
    tick();
    for (int w = 2; w <= TO; w++) begin
      tick();
      check("wd_wait_err", err, 0);
    end
    tick();
    $display("watchdog expiry pair p=0 q=2");
    check("wd_err", err, 1);
    check("wd_busy", busy, 0);
    check("wd_p_hold", p, 0);
    check("wd_q_hold", q, 2);
    sincos_valid = 1'b1;
    tick();
    sincos_valid = 1'b0;
    tick();
    check("err_held", err, 1);
    check("err_no_rot_start", rot_start, 0);
    check("err_p_frozen", p, 0);
    check("err_q_frozen", q, 2);

    // Restart from ERR, then reset mid-WAIT_ROT.
    start_pulse();
    tick();
    do_pair(1, 1, 0, 1, 1'b0);
    tick();
    check("rst_pre_q", q, 2);
    tick();
    sincos_valid = 1'b1;
    tick();
    sincos_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    $display("reset mid WAIT_ROT");
    check_idle_flags("midrst");
    tick();
    rst = 1'b0;
    rot_done = 1'b1;
    tick();
    rot_done = 1'b0;
    tick();
    check_idle_flags("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
